// File: rtl/titan_wb_ram_slave.sv
// titan_wb_ram_slave: Wishbone classic single-transfer responder backed by
// on-chip word RAM. It decodes an aligned address window and can add
// programmable wait states. Writes honour the byte-lane selects. Each
// transfer ends with exactly one ack or err pulse.
module titan_wb_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          err_q, err_d;

    // Request decode on the live bus inputs. Only the IDLE capture uses it.
    logic          req;
    logic [31:0]   req_off;
    logic          req_err;
    logic [AW-1:0] req_idx;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign req_off = wbs_addr_i - BASE_ADDR;
    // BASE_ADDR is window aligned. An address below the base wraps to a large
    // offset, so a single upper-bits test covers both ends of the window.
    assign req_err = (req_off[31:AW+2] != '0) | (req_off[1:0] != 2'b00);
    assign req_idx = req_off[AW+1:2];

    // Word RAM with a registered read port.
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   rdata_q;
    logic [AW-1:0] rd_idx;
    logic          mem_we;
    logic [3:0]    lane_we;

    // The read address follows the live bus in IDLE, so the RESP-entry edge of
    // a zero-wait transfer already samples the correct word. It follows the
    // latched index afterwards.
    assign rd_idx = (state_q == S_IDLE) ? req_idx : idx_q;

    // A write commits only on the RESP edge of a decoded, in-window transfer.
    assign mem_we = (state_q == S_RESP) & we_q & ~err_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = mem_we & sel_q[gi];
        end
    endgenerate

    // RAM write lanes and synchronous read. The RAM contents are never reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
            end
        end
        rdata_q <= mem[rd_idx];
    end

    // State and latched request registers. An asynchronous reset drops any
    // pending transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture in IDLE, count down wait states, respond once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    dat_d   = wbs_dat_i;
                    sel_d   = wbs_sel_i;
                    we_d    = wbs_we_i;
                    err_d   = req_err;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT_CNT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // The master abandoning the cycle takes priority over the countdown.
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response outputs are decoded from registered state. Read data shows only
    // during a read ack and is zero at all other times.
    assign wbs_ack_o = (state_q == S_RESP) & ~err_q;
    assign wbs_err_o = (state_q == S_RESP) &  err_q;
    assign wbs_dat_o = (wbs_ack_o & ~we_q) ? rdata_q : 32'h0000_0000;

endmodule
